periph_bus_arbiter: RTL
=======================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - DMEM_BASE, 32'h0010_0000, DMEM byte base.
  - DMEM_SIZE, 65536, DMEM window size in bytes.
  - UART_BASE, 32'h0100_0000, UART byte base.
  - UART_SIZE, 16, UART window size in bytes.
  - TIMEOUT_CYCLES, 255, maximum BUSY wait.
REQ-002 The clock SHALL be clk_i (input, 1), the only clock; all flops on its rising edge.
REQ-003 Reset SHALL be rst_i (input, 1), asynchronous and active-high.
REQ-004 Each master port, N = 0 (core data port) and N = 1 (loader/DMA), SHALL have these inputs:
  - mN_req_i (1): request.
  - mN_we_i (1): write.
  - mN_addr_i (32): byte address.
  - mN_wdata_i (32): write data.
  - mN_wstrb_i (4): byte strobes.
REQ-005 Each master port SHALL have these outputs:
  - mN_gnt_o (1): request accepted.
  - mN_rvalid_o (1): response.
  - mN_rdata_o (32): read data.
  - mN_err_o (1): error flag, qualified by rvalid.
REQ-006 Shared slave outputs SHALL be:
  - dmem_req_o (1), uart_req_o (1): per-slave request strobes.
  - s_we_o (1), s_addr_o (32), s_wdata_o (32), s_wstrb_o (4).
REQ-007 Slave inputs SHALL be dmem_rvalid_i (1), dmem_rdata_i (32), uart_rvalid_i (1) and uart_rdata_i (32).

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, BUSY and RESP; at most one transaction is outstanding.
REQ-009 In IDLE, a request SHALL be granted in the same cycle; gnt_o is a 1-cycle pulse and is combinational from req_i.
REQ-010 Simultaneous requests SHALL be resolved round-robin: the master not granted last wins; a single requester always wins.
REQ-011 Decode SHALL test BASE <= addr < BASE+SIZE using 33-bit arithmetic, so the window end never wraps.
REQ-012 A mapped grant SHALL, in the grant cycle:
  - pulse exactly one of dmem_req_o / uart_req_o for 1 cycle;
  - drive s_* from the winner;
  - register owner and target;
  - go to BUSY.
REQ-013 An unmapped grant SHALL pulse no slave request and SHALL go directly to RESP with error set and rdata 0.
REQ-014 In BUSY, the rvalid of the registered target SHALL latch that slave's rdata and go to RESP; the other slave's rvalid is ignored.
REQ-015 In RESP, the owner's rvalid_o SHALL pulse for 1 cycle with the latched rdata/err, then the FSM returns to IDLE.
REQ-016 Minimum latency SHALL be grant -> rvalid_o in 2 cycles (slave rvalid in the cycle after grant).
REQ-017 Writes SHALL receive a response like reads; rdata_o is whatever the slave returned.
REQ-018 gnt_o SHALL be 0 outside IDLE; requests held in BUSY/RESP wait, with no loss and no reorder.
REQ-019 When inactive, s_* outputs SHALL be 0; the non-owner's rvalid_o SHALL never pulse.
REQ-020 A slave rvalid arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-021 During reset all outputs SHALL be 0, the FSM SHALL be IDLE, and the last-grant record SHALL be m1 (so m0 wins first).
REQ-022 Reset mid-transaction SHALL abort silently: no rvalid to the owner, and a later stale slave rvalid is ignored.

Configuration
REQ-023 Macro PERIPH_BUS_TIMEOUT_EN SHALL control the BUSY timeout as follows:
  - Defined: an 8-bit counter clears on BUSY entry and increments each BUSY cycle; on reaching TIMEOUT_CYCLES without target rvalid, the FSM goes to RESP with err = 1 and rdata = 0.
  - Undefined: the counter is absent and BUSY waits indefinitely.

Structure
REQ-024 Package periph_bus_pkg SHALL hold:
  - the state enum (IDLE/BUSY/RESP);
  - the target enum (NONE/DMEM/UART);
  - the default base/size localparams.
REQ-025 The round-robin choice SHALL live in sub-module rr_arbiter2 (inputs req[1:0] and last; output grant one-hot).

Verification
REQ-026 m0 reads 0x0010_0004 and DMEM answers the next cycle with 0xDEADBEEF -> m0_rvalid_o pulses with 0xDEADBEEF, err = 0, 2 cycles after grant.
REQ-027 m0 and m1 both request continuously after reset -> grants alternate m0, m1, m0, m1 and each rvalid goes to the correct owner.
REQ-028 m1 writes 0x41 to 0x0100_0000 with wstrb 0001 -> uart_req_o pulses once with s_wdata_o = 0x41, dmem_req_o stays 0, and m1 gets its response.
REQ-029 m0 accesses 0x0001_0000 and, separately, 0x0010_FFFF+1 -> no slave request, m0_err_o = 1, rdata 0, in the cycle after grant.
REQ-030 With PERIPH_BUS_TIMEOUT_EN, a DMEM request that is never answered -> err response after 255 BUSY cycles, and a late dmem_rvalid_i is ignored.
REQ-031 rst_i is asserted while in BUSY and the stale slave rvalid arrives after release -> no rvalid_o, and the next m0 request is granted normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types, default address map and decode helper for the peripheral bus arbiter.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DMEM = 2'd1,
        UART = 2'd2
    } target_e;

    localparam logic [31:0] DEF_DMEM_BASE      = 32'h0010_0000;
    localparam int unsigned DEF_DMEM_SIZE      = 65536;
    localparam logic [31:0] DEF_UART_BASE      = 32'h0100_0000;
    localparam int unsigned DEF_UART_SIZE      = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Window end is formed in 33 bits so a window touching 4 GiB never wraps to 0.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + size;
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr.sv
// Two-way round-robin pick: with both requesting, the master not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master, two-slave single-outstanding bus arbiter (DMEM + UART windows).
// Optional BUSY timeout is enabled by defining PERIPH_BUS_TIMEOUT_EN.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE      = DEF_DMEM_BASE,
    parameter int unsigned DMEM_SIZE      = DEF_DMEM_SIZE,
    parameter logic [31:0] UART_BASE      = DEF_UART_BASE,
    parameter int unsigned UART_SIZE      = DEF_UART_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        dmem_req_o,
    output logic        uart_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,

    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        uart_rvalid_i,
    input  logic [31:0] uart_rdata_i
);

    localparam logic [32:0] DMEM_SIZE_W = 33'(DMEM_SIZE);
    localparam logic [32:0] UART_SIZE_W = 33'(UART_SIZE);

    state_e      state_q, state_d;
    target_e     target_q, target_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef PERIPH_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    logic        arb_en;
    logic [1:0]  grant;
    logic        win_sel;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;
    logic        hit_dmem;
    logic        hit_uart;
    logic        tgt_rvalid;
    logic [31:0] tgt_rdata;

    // Arbitration is only open in IDLE and outside reset, so gnt stays low otherwise.
    assign arb_en = (state_q == IDLE) && !rst_i;

    rr_arbiter2 u_rr (
        .req   ({m1_req_i, m0_req_i} & {2{arb_en}}),
        .last  (last_q),
        .grant (grant)
    );

    assign win_sel   = grant[1];
    assign win_we    = win_sel ? m1_we_i    : m0_we_i;
    assign win_addr  = win_sel ? m1_addr_i  : m0_addr_i;
    assign win_wdata = win_sel ? m1_wdata_i : m0_wdata_i;
    assign win_wstrb = win_sel ? m1_wstrb_i : m0_wstrb_i;

    assign hit_dmem = in_window(win_addr, DMEM_BASE, DMEM_SIZE_W);
    assign hit_uart = !hit_dmem && in_window(win_addr, UART_BASE, UART_SIZE_W);

    assign tgt_rvalid = ((target_q == DMEM) && dmem_rvalid_i) ||
                        ((target_q == UART) && uart_rvalid_i);
    assign tgt_rdata  = (target_q == UART) ? uart_rdata_i : dmem_rdata_i;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        owner_d    = owner_q;
        last_d     = last_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        dmem_req_o = 1'b0;
        uart_req_o = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
`ifdef PERIPH_BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = win_sel;
                    last_d  = win_sel;
                    if (hit_dmem || hit_uart) begin
                        dmem_req_o = hit_dmem;
                        uart_req_o = hit_uart;
                        s_we_o     = win_we;
                        s_addr_o   = win_addr;
                        s_wdata_o  = win_wdata;
                        s_wstrb_o  = win_wstrb;
                        target_d   = hit_dmem ? DMEM : UART;
                        state_d    = BUSY;
`ifdef PERIPH_BUS_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        target_d = NONE;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                        state_d  = RESP;
                    end
                end
            end
            BUSY: begin
                if (tgt_rvalid) begin
                    rdata_d = tgt_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
`ifdef PERIPH_BUS_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            RESP: begin
                target_d = NONE;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            target_q <= NONE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef PERIPH_BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            err_q    <= err_d;
`ifdef PERIPH_BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Read data is only observed when qualified by rvalid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
    end

    assign m0_gnt_o    = grant[0];
    assign m1_gnt_o    = grant[1];
    assign m0_rvalid_o = (state_q == RESP) && !owner_q;
    assign m1_rvalid_o = (state_q == RESP) &&  owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
    assign m0_err_o    = m0_rvalid_o && err_q;
    assign m1_err_o    = m1_rvalid_o && err_q;

endmodule
